// File: rtl/lut_layer_pkg.sv
// Shared types and helpers for the runtime-reloadable LUT neuron layer.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DRAIN
  } lut_state_e;

  function automatic int table_aw(input int fanin, input int in_bits);
    return fanin * in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron truth table: DEPTH x OUT_BITS storage, synchronous write, asynchronous read.
// LUT_LAYER_READBACK_EN adds a second asynchronous read port for table readback.
module lut_neuron_ram #(
  parameter int AW       = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [OUT_BITS-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [OUT_BITS-1:0] o_rdata
`ifdef LUT_LAYER_READBACK_EN
  ,
  input  logic [AW-1:0]       i_rb_addr,
  output logic [OUT_BITS-1:0] o_rb_data
`endif
);

  logic [OUT_BITS-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

`ifdef LUT_LAYER_READBACK_EN
  assign o_rb_data = r_mem[i_rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_layer_rt.sv
// Pipelined layer of truth-table neurons whose tables are reloaded over a config stream.
// Optional table readback port enabled by defining LUT_LAYER_READBACK_EN.
module lut_neuron_layer_rt
  import lut_layer_pkg::*;
#(
  parameter  int NUM_NEURONS = 8,
  parameter  int FANIN       = 4,
  parameter  int IN_BITS     = 2,
  parameter  int OUT_BITS    = 2,
  localparam int AW          = table_aw(FANIN, IN_BITS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*AW-1:0]       in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_load,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_done
`ifdef LUT_LAYER_READBACK_EN
  ,
  input  logic                            rd_en,
  input  logic [$clog2(NUM_NEURONS)-1:0]  rd_neuron,
  input  logic [AW-1:0]                   rd_addr,
  output logic                            rd_valid,
  output logic [OUT_BITS-1:0]             rd_data
`endif
);

  localparam int DEPTH = 2**AW;
  localparam int TOTAL = NUM_NEURONS * DEPTH;
  localparam int CW    = $clog2(TOTAL + 1);

  lut_state_e                      r_state;
  logic [CW-1:0]                   r_count;
  logic                            r_cfg_done;
  logic                            r_s1_valid;
  logic [NUM_NEURONS*AW-1:0]       r_s1_data;
  logic                            r_out_valid;
  logic [NUM_NEURONS*OUT_BITS-1:0] r_out_data;

  logic                            w_adv;
  logic                            w_in_fire;
  logic                            w_cfg_fire;
  logic [CW-1:0]                   w_wr_idx;
  logic [CW-1:0]                   w_wr_sel;
  logic                            w_wr_last;
  logic [NUM_NEURONS*OUT_BITS-1:0] w_lut;

  assign cfg_ready  = (r_state == LOAD);
  assign w_cfg_fire = cfg_valid && cfg_ready;
  // A word arriving with cfg_load is taken as word 0 of the restarted load.
  assign w_wr_idx   = cfg_load ? '0 : r_count;
  assign w_wr_sel   = w_wr_idx >> AW;
  assign w_wr_last  = (w_wr_idx == CW'(TOTAL - 1));

  assign w_adv      = !r_out_valid || out_ready;
  assign in_ready   = (r_state == RUN) && (!r_s1_valid || w_adv);
  assign w_in_fire  = in_valid && in_ready;

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign cfg_done   = r_cfg_done;

`ifdef LUT_LAYER_READBACK_EN
  logic [OUT_BITS-1:0] w_rb [NUM_NEURONS];
`endif

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    lut_neuron_ram #(
      .AW       (AW),
      .OUT_BITS (OUT_BITS)
    ) u_ram (
      .i_clk     (clk),
      .i_we      (w_cfg_fire && (w_wr_sel == CW'(n))),
      .i_waddr   (w_wr_idx[AW-1:0]),
      .i_wdata   (cfg_data),
      .i_raddr   (r_s1_data[n*AW +: AW]),
      .o_rdata   (w_lut[n*OUT_BITS +: OUT_BITS])
`ifdef LUT_LAYER_READBACK_EN
      ,
      .i_rb_addr (rd_addr),
      .o_rb_data (w_rb[n])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOAD;
      r_count    <= '0;
      r_cfg_done <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_cfg_fire) begin
            if (w_wr_last) begin
              r_state    <= RUN;
              r_count    <= '0;
              r_cfg_done <= 1'b1;
            end else begin
              r_count <= w_wr_idx + CW'(1);
            end
          end else if (cfg_load) begin
            r_count <= '0;
          end
        end
        RUN: begin
          if (cfg_load) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_s1_valid && !r_out_valid) begin
            r_state <= LOAD;
            r_count <= '0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) r_out_data <= w_lut;
      end
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= in_data;
      end else if (w_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

`ifdef LUT_LAYER_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= w_rb[rd_neuron];
    end
  end
`endif

endmodule

// File: tb/tb_lut_neuron_layer_rt.sv
// Directed self-checking bench for lut_neuron_layer_rt (2 neurons, 8-bit addresses, 2-bit outputs).
// Readback checks are included when LUT_LAYER_READBACK_EN is defined.
module tb_lut_neuron_layer_rt;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        cfg_load;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_data;
  logic        cfg_done;
`ifdef LUT_LAYER_READBACK_EN
  logic        rd_en;
  logic        rd_neuron;
  logic [7:0]  rd_addr;
  logic        rd_valid;
  logic [1:0]  rd_data;
`endif

  int n_vec = 0;
  int n_err = 0;
  int pulses;
  int pulse_pos;
  logic [1:0] tbl [2][256];

  lut_neuron_layer_rt #(
    .NUM_NEURONS (2),
    .FANIN       (4),
    .IN_BITS     (2),
    .OUT_BITS    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_load  (cfg_load),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done)
`ifdef LUT_LAYER_READBACK_EN
    ,
    .rd_en     (rd_en),
    .rd_neuron (rd_neuron),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] tword(input int sel, input int n, input logic [7:0] a);
    case (sel)
      0:       return (n == 0) ? a[7:6] : ~a[1:0];
      1:       return (n == 0) ? a[1:0] : ~a[1:0];
      default: return (n == 0) ? a[1:0] : a[3:2];
    endcase
  endfunction

  function automatic logic [3:0] bexp(input logic [15:0] d);
    return {tbl[1][d[15:8]], tbl[0][d[7:0]]};
  endfunction

  // Writes the first nwords words of table set sel; records cfg_done pulses and their position.
  task automatic load(input int sel, input int nwords, input bit coll);
    logic [7:0] a;
    int n;
    pulses = 0;
    pulse_pos = -1;
    for (int k = 0; k < nwords; k++) begin
      n = k / 256;
      a = 8'(k % 256);
      cfg_valid = 1'b1;
      cfg_data  = tword(sel, n, a);
      tbl[n][a] = cfg_data;
      if (k == 0) begin
        #1;
        chk("load_cfg_ready", cfg_ready, 1);
      end
      if (k == 511) chk("in_ready_before_last", in_ready, 0);
`ifdef LUT_LAYER_READBACK_EN
      if (coll && k == 5) begin
        rd_en = 1'b1; rd_neuron = 1'b0; rd_addr = 8'h05;
      end
`endif
      tick();
      if (cfg_done) begin pulses++; pulse_pos = k; end
`ifdef LUT_LAYER_READBACK_EN
      if (coll && k == 5) begin
        chk("rb_coll_valid", rd_valid, 1);
        chk("rb_coll_old", rd_data, 2'b00);
        rd_en = 1'b0;
      end
`endif
    end
    cfg_valid = 1'b0;
    tick();
    if (cfg_done) begin pulses++; pulse_pos = 512; end
  endtask

  task automatic beat(input string tag, input logic [15:0] d, input logic [3:0] exp);
    in_valid = 1'b1; out_ready = 1'b1; in_data = d;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk({tag, "_lat1"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    tick();
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    logic [3:0] q [$];
    logic [3:0] held;
    logic [7:0] a0, a1;
    bit stalled;
    int sent, got, cyc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_load = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
`ifdef LUT_LAYER_READBACK_EN
    rd_en = 1'b0; rd_neuron = 1'b0; rd_addr = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_done", cfg_done, 0);
`ifdef LUT_LAYER_READBACK_EN
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
`endif
    tick();

    // Initial load: n0[a]=a[7:6], n1[a]=~a[1:0]
    load(0, 512, 1'b0);
    chk("load0_pulses", pulses, 1);
    chk("load0_pulse_pos", pulse_pos, 511);
    chk("load0_in_ready", in_ready, 1);
    chk("load0_cfg_ready", cfg_ready, 0);

`ifdef LUT_LAYER_READBACK_EN
    rd_en = 1'b1; rd_neuron = 1'b1; rd_addr = 8'h02;
    tick();
    rd_en = 1'b0;
    chk("rb_valid", rd_valid, 1);
    chk("rb_data", rd_data, 2'b01);
    tick();
    chk("rb_valid_clr", rd_valid, 0);
`endif

    beat("single", {8'h01, 8'hC0}, 4'b1011);

    // Back-to-back stream with out_ready low 3 of every 10 cycles
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < 256 && cyc < 3000) begin
      out_ready = (cyc % 10) < 7;
      in_valid  = (sent < 256);
      a0 = 8'(sent);
      a1 = 8'(sent * 37 + 5);
      in_data = {a1, a0};
      #1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() > 0) chk("stream_data", out_data, q.pop_front());
        else chk("stream_extra", out_valid, 0);
        got++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        q.push_back({~a1[1:0], a0[7:6]});
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", got, 256);
    chk("stream_queue_empty", q.size(), 0);
    tick(); tick();
    chk("stream_idle", out_valid, 0);

    // Reload request with two beats in flight and downstream stalled
    out_ready = 1'b0; in_valid = 1'b1; in_data = {8'h01, 8'hC0};
    #1;
    chk("drain_a_ready", in_ready, 1);
    tick();
    in_data = {8'h03, 8'h40}; cfg_load = 1'b1;
    #1;
    chk("drain_b_ready", in_ready, 1);
    tick();
    cfg_load = 1'b0; in_data = {8'h11, 8'h22};
    #1;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_cfg_ready", cfg_ready, 0);
    chk("drain_a_valid", out_valid, 1);
    chk("drain_a_data", out_data, 4'b1011);
    tick();
    chk("drain_in_ready2", in_ready, 0);
    chk("drain_a_hold", out_data, 4'b1011);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_b_valid", out_valid, 1);
    chk("drain_b_data", out_data, 4'b0001);
    tick();
    chk("drain_empty", out_valid, 0);
    for (int i = 0; i < 10 && !cfg_ready; i++) tick();
    chk("drain_to_load", cfg_ready, 1);
    chk("drain_in_ready3", in_ready, 0);

    // Reload n0[a]=a[1:0]; readback collision at n0 address 5
    load(1, 512, 1'b1);
    chk("load1_pulses", pulses, 1);
    chk("load1_pulse_pos", pulse_pos, 511);
    beat("reload", {8'h01, 8'hC0}, 4'b1000);
    chk("reload_model", bexp({8'h01, 8'hC0}), 4'b1000);

    // Reset part-way through a load
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 10 && !cfg_ready; i++) tick();
    load(2, 300, 1'b0);
    rst = 1'b1; cfg_valid = 1'b1; cfg_data = 2'b11;
    tick();
    rst = 1'b0; cfg_valid = 1'b0;
    #1;
    chk("abort_pulses", pulses, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    chk("abort_cfg_done", cfg_done, 0);
    tick(); tick();
    chk("abort_in_ready2", in_ready, 0);
    load(2, 512, 1'b0);
    chk("load2_pulses", pulses, 1);
    chk("load2_pulse_pos", pulse_pos, 511);
    chk("load2_in_ready", in_ready, 1);
    beat("after_abort", {8'h0C, 8'hC1}, 4'b1101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
